// File: rtl/fir_mac_multi_if.sv
// Sample/coefficient/result bundle between the band sequencer and one FIR engine.
interface fir_mac_multi_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10
);
    logic                       sequencing;
    logic [NUM_CH*DATA_W-1:0]   smpl_in;
    logic [ADDR_W-1:0]          coef_addr;
    logic [COEF_W-1:0]          coef_data;
    logic [NUM_CH*DATA_W-1:0]   smpl_out;
    logic                       out_vld;
    logic                       tap_ovf;

    // sequencer side: supplies window, samples and coefficient read data
    modport master (
        output sequencing, smpl_in, coef_data,
        input  coef_addr, smpl_out, out_vld, tap_ovf
    );

    // FIR engine side
    modport slave (
        input  sequencing, smpl_in, coef_data,
        output coef_addr, smpl_out, out_vld, tap_ovf
    );
endinterface

// File: rtl/fir_mac_multi.sv
// Multi-channel MAC FIR engine: one shared coefficient stream, NUM_CH
// parallel accumulators, saturated registered result with a valid strobe.
//
// state | meaning
// IDLE  | waiting for sequencing; coef_addr parked at 0 so coef[0] is prefetched
// CONV  | accumulating one product per channel per cycle until sequencing falls
module fir_mac_multi #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 1023,
    parameter int NUM_CH   = 2,
    parameter int FRAC     = 15,
    parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
    input  logic           clk,
    input  logic           rst_n,
    fir_mac_multi_if.slave bus
);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0]  TAP_LAST = CNT_W'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NUM_TAPS - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc [NUM_CH];
    logic [CNT_W-1:0]          tap_cnt;
    logic [ADDR_W-1:0]         coef_addr;
    logic [NUM_CH*DATA_W-1:0]  smpl_out;
    logic                      out_vld;
    logic                      tap_ovf;

    logic signed [COEF_W-1:0]  coef_s;
    logic signed [DATA_W-1:0]  smpl_s  [NUM_CH];
    logic signed [PROD_W-1:0]  prod    [NUM_CH];
    logic signed [ACC_W-1:0]   shifted [NUM_CH];
    logic [DATA_W-1:0]         sat_val [NUM_CH];

    assign coef_s       = bus.coef_data;
    assign bus.coef_addr = coef_addr;
    assign bus.smpl_out  = smpl_out;
    assign bus.out_vld   = out_vld;
    assign bus.tap_ovf   = tap_ovf;

    // Per-channel full-precision product and the saturated, rescaled accumulator.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            smpl_s[ch]  = bus.smpl_in[ch*DATA_W +: DATA_W];
            prod[ch]    = PROD_W'(smpl_s[ch]) * PROD_W'(coef_s);
            shifted[ch] = acc[ch] >>> FRAC;
            sat_val[ch] = shifted[ch][DATA_W-1:0];
            // in range only if all bits above the result sign agree with it
            if (!(&shifted[ch][ACC_W-1:DATA_W-1]) && (|shifted[ch][ACC_W-1:DATA_W-1])) begin
                if (shifted[ch][ACC_W-1])
                    sat_val[ch] = {1'b1, {(DATA_W-1){1'b0}}};
                else
                    sat_val[ch] = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

    // Window FSM, accumulators, address generator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            coef_addr <= '0;
            smpl_out  <= '0;
            out_vld   <= 1'b0;
            tap_ovf   <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
        end else begin
            out_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sequencing) begin
                        // coef[0] is already being read from address 0
                        for (int ch = 0; ch < NUM_CH; ch++) acc[ch] <= '0;
                        tap_cnt   <= '0;
                        coef_addr <= ADDR_W'(1);
                        tap_ovf   <= 1'b0;
                        state     <= CONV;
                    end else begin
                        coef_addr <= '0;
                    end
                end
                CONV: begin
                    if (bus.sequencing) begin
                        if (tap_cnt == TAP_LAST) begin
                            tap_ovf <= 1'b1;
                        end else begin
                            for (int ch = 0; ch < NUM_CH; ch++)
                                acc[ch] <= acc[ch] + ACC_W'(prod[ch]);
                            tap_cnt <= tap_cnt + CNT_W'(1);
                        end
                        if (coef_addr != ADDR_MAX)
                            coef_addr <= coef_addr + ADDR_W'(1);
                    end else begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                            smpl_out[ch*DATA_W +: DATA_W] <= sat_val[ch];
                        out_vld   <= 1'b1;
                        coef_addr <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_multi.sv
// Directed + randomized bench for fir_mac_multi with an arithmetic reference model.
module tb_fir_mac_multi;
    localparam int NT = 8;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NC = 2;
    localparam int AW = 3;

    logic clk;
    logic rst_n;

    fir_mac_multi_if #(.DATA_W(DW), .COEF_W(CW), .NUM_CH(NC), .ADDR_W(AW)) bus ();

    fir_mac_multi #(
        .DATA_W(DW), .COEF_W(CW), .NUM_TAPS(NT), .NUM_CH(NC), .FRAC(15), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic signed [CW-1:0] coef_mem [NT];
    logic signed [DW-1:0] s_tab [NC][16];
    logic signed [DW-1:0] last_exp [NC];
    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous coefficient ROM, one cycle read latency
    always @(posedge clk) bus.coef_data <= coef_mem[bus.coef_addr];

    // count strobe cycles
    always @(negedge clk) if (bus.out_vld === 1'b1) pulses++;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // expected result: sum of the first min(n_high-1, NT) products, >>> 15, clamped
    function automatic logic signed [DW-1:0] model(input int ch, input int n_high);
        longint acc = 0;
        int nprod = n_high - 1;
        if (nprod > NT) nprod = NT;
        for (int k = 0; k < nprod; k++)
            acc += longint'(s_tab[ch][k]) * longint'(coef_mem[k]);
        acc = acc >>> 15;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return DW'(acc);
    endfunction

    task automatic idle(input int n);
        bus.sequencing = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // sequencing high for n_high cycles, then low; ends on the strobe cycle
    task automatic run_window(input int n_high, input string tag);
        logic signed [DW-1:0] exp_out [NC];
        int exp_addr;
        for (int ch = 0; ch < NC; ch++) exp_out[ch] = model(ch, n_high);
        bus.sequencing = 1'b1;
        for (int c = 0; c < n_high; c++) begin
            if (c > 0) bus.smpl_in = {s_tab[1][c-1], s_tab[0][c-1]};
            @(negedge clk);
            if (c == 0) begin
                check({tag, "_ovf_clr"}, bus.tap_ovf, 0);
                check({tag, "_addr_start"}, bus.coef_addr, 1);
            end
            if (c == n_high - 1) begin
                exp_addr = (c + 1 < NT - 1) ? c + 1 : NT - 1;
                check({tag, "_addr_end"}, bus.coef_addr, exp_addr);
                check({tag, "_hold0"}, $signed(bus.smpl_out[0 +: DW]), last_exp[0]);
            end
        end
        bus.sequencing = 1'b0;
        bus.smpl_in = {NC{DW'($urandom)}};
        @(negedge clk);
        check({tag, "_vld"}, bus.out_vld, 1);
        check({tag, "_ch0"}, $signed(bus.smpl_out[0 +: DW]), exp_out[0]);
        check({tag, "_ch1"}, $signed(bus.smpl_out[DW +: DW]), exp_out[1]);
        check({tag, "_ovf"}, bus.tap_ovf, (n_high - 1 > NT) ? 1 : 0);
        check({tag, "_addr_idle"}, bus.coef_addr, 0);
        for (int ch = 0; ch < NC; ch++) last_exp[ch] = exp_out[ch];
    endtask

    task automatic rand_data();
        for (int k = 0; k < NT; k++) coef_mem[k] = CW'($urandom);
        for (int ch = 0; ch < NC; ch++)
            for (int k = 0; k < 16; k++) s_tab[ch][k] = DW'($urandom);
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        bus.sequencing = 1'b0;
        bus.smpl_in = '0;
        for (int k = 0; k < NT; k++) coef_mem[k] = '0;
        for (int ch = 0; ch < NC; ch++) last_exp[ch] = '0;
        repeat (3) @(negedge clk);
        check("rst_out", bus.smpl_out, 0);
        check("rst_vld", bus.out_vld, 0);
        check("rst_ovf", bus.tap_ovf, 0);
        check("rst_addr", bus.coef_addr, 0);
        rst_n = 1'b1;
        idle(2);

        // impulse
        coef_mem[0] = 16'sh7FFF;
        for (int k = 0; k < 16; k++) begin
            s_tab[0][k] = (k == 0) ? 16'sd1000 : 16'sd0;
            s_tab[1][k] = DW'($urandom);
        end
        p0 = pulses;
        run_window(NT + 1, "impulse");
        check("impulse_ch0_val", $signed(bus.smpl_out[0 +: DW]), 999);
        idle(1);
        check("impulse_pulses", pulses - p0, 1);
        check("impulse_vld_drop", bus.out_vld, 0);
        idle(2);

        // saturation
        for (int k = 0; k < NT; k++) coef_mem[k] = 16'sh4000;
        for (int ch = 0; ch < NC; ch++) for (int k = 0; k < 16; k++) s_tab[ch][k] = 16'sh7FFF;
        run_window(NT + 1, "sat_pos");
        check("sat_pos_val", bus.smpl_out[0 +: DW], 16'h7FFF);
        idle(3);
        for (int ch = 0; ch < NC; ch++) for (int k = 0; k < 16; k++) s_tab[ch][k] = -16'sh8000;
        run_window(NT + 1, "sat_neg");
        check("sat_neg_val", bus.smpl_out[0 +: DW], 16'h8000);
        idle(3);

        // channel independence
        for (int k = 0; k < NT; k++) coef_mem[k] = (k < 4) ? 16'sh2000 : 16'sh0;
        for (int k = 0; k < 16; k++) begin
            s_tab[0][k] = 16'sd500;
            s_tab[1][k] = -16'sd500;
        end
        run_window(5, "indep");
        check("indep_ch0_val", $signed(bus.smpl_out[0 +: DW]), 500);
        check("indep_ch1_val", $signed(bus.smpl_out[DW +: DW]), -500);
        idle(2);

        // tap overrun, then a short window clears the flag
        rand_data();
        run_window(12, "ovrun");
        idle(2);
        check("ovrun_sticky", bus.tap_ovf, 1);
        run_window(3, "after_ovrun");
        idle(2);

        // zero-product window
        run_window(1, "empty");
        idle(2);

        // back-to-back windows with a single low cycle between them
        rand_data();
        p0 = pulses;
        run_window(6, "b2b_a");
        rand_data();
        run_window(4, "b2b_b");
        idle(1);
        check("b2b_pulses", pulses - p0, 2);
        idle(2);

        // randomized windows
        for (int i = 0; i < 8; i++) begin
            rand_data();
            p0 = pulses;
            run_window($urandom_range(1, 13), "rand");
            idle(1 + $urandom_range(0, 2));
            check("rand_pulses", pulses - p0, 1);
        end

        // reset in the middle of a window
        rand_data();
        p0 = pulses;
        bus.sequencing = 1'b1;
        repeat (4) begin
            bus.smpl_in = {DW'($urandom), DW'($urandom)};
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out", bus.smpl_out, 0);
        check("midrst_vld", bus.out_vld, 0);
        check("midrst_ovf", bus.tap_ovf, 0);
        check("midrst_addr", bus.coef_addr, 0);
        bus.sequencing = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("midrst_no_strobe", pulses - p0, 0);
        check("midrst_out_after", bus.smpl_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
